// File: rtl/serializer_stream_if.sv
// serializer_stream parallel-in / serial-out bus bundle.
// master = word producer side, slave = serializer side.
interface serializer_stream_if #(
  parameter int DATA_BUS_WIDTH = 16
);
  localparam int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH);

  logic [DATA_BUS_WIDTH-1:0] data_i;
  logic [DATA_MOD_WIDTH-1:0] data_mod_i;
  logic                      data_val_i;
  logic                      ready_o;
  logic                      ser_data_o;
  logic                      ser_data_val_o;
  logic                      busy_o;
  logic                      drop_o;

  modport master (
    output data_i,
    output data_mod_i,
    output data_val_i,
    input  ready_o,
    input  ser_data_o,
    input  ser_data_val_o,
    input  busy_o,
    input  drop_o
  );

  modport slave (
    input  data_i,
    input  data_mod_i,
    input  data_val_i,
    output ready_o,
    output ser_data_o,
    output ser_data_val_o,
    output busy_o,
    output drop_o
  );
endinterface

// File: rtl/serializer_stream.sv
// serializer_stream: length-tagged words out one bit per clock.
// One-word pending buffer keeps back-to-back words gap-free.
module serializer_stream #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH),
  parameter int MIN_LEN        = 3,
  parameter bit LSB_FIRST      = 1'b0
) (
  input logic                clk_i,
  input logic                arstn_i,
  serializer_stream_if.slave bus
);

  localparam int W  = DATA_BUS_WIDTH;
  localparam int CW = DATA_MOD_WIDTH + 1;

  localparam logic [1:0] IDLE_S  = 2'b01;
  localparam logic [1:0] SHIFT_S = 2'b10;

  logic [1:0]    state;
  logic [W-1:0]  shreg;
  logic [W-1:0]  shreg_nxt;
  logic [CW-1:0] cnt;
  logic          val_q;
  logic          drop_q;
  logic          pend_v;
  logic [W-1:0]  pend_data;
  logic [CW-1:0] pend_len;

  logic [CW-1:0] len;
  logic          len_ok;
  logic          offer;
  logic          accept;
  logic          reject;
  logic          idle;
  logic          shifting;
  logic          last;
  logic          load_new;
  logic          load_pend;
  logic          pend_wr;

  assign len = (bus.data_mod_i == '0) ? CW'(W)
                                      : {1'b0, bus.data_mod_i};
  assign len_ok = (len >= CW'(MIN_LEN));

  assign offer  = bus.data_val_i && !pend_v;
  assign accept = offer && len_ok;
  assign reject = offer && !len_ok;

  assign idle      = (state == IDLE_S);
  assign shifting  = (state == SHIFT_S);
  assign last      = (cnt == CW'(1));
  assign load_pend = shifting && last && pend_v;
  assign load_new  = accept &&
                     (idle || (shifting && last && !pend_v));
  assign pend_wr   = accept && shifting && !last;

  assign shreg_nxt = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

  // Shift FSM: load, shift, chain to next word or fall idle.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state <= IDLE_S;
      shreg <= '0;
      cnt   <= '0;
      val_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE_S: begin
          if (load_new) begin
            state <= SHIFT_S;
            shreg <= bus.data_i;
            cnt   <= len;
            val_q <= 1'b1;
          end
        end
        SHIFT_S: begin
          if (!last) begin
            shreg <= shreg_nxt;
            cnt   <= cnt - CW'(1);
          end else if (load_pend) begin
            shreg <= pend_data;
            cnt   <= pend_len;
          end else if (load_new) begin
            shreg <= bus.data_i;
            cnt   <= len;
          end else begin
            state <= IDLE_S;
            shreg <= '0;
            cnt   <= '0;
            val_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE_S;
          shreg <= '0;
          cnt   <= '0;
          val_q <= 1'b0;
        end
      endcase
    end
  end

  // Pending slot: filled mid-word, drained on the last bit.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pend_v    <= 1'b0;
      pend_data <= '0;
      pend_len  <= '0;
    end else if (pend_wr) begin
      pend_v    <= 1'b1;
      pend_data <= bus.data_i;
      pend_len  <= len;
    end else if (load_pend) begin
      pend_v    <= 1'b0;
    end
  end

  // Too-short words are dropped with a one-cycle flag.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= reject;
    end
  end

  assign bus.ser_data_o     = LSB_FIRST ? shreg[0] : shreg[W-1];
  assign bus.ser_data_val_o = val_q;
  assign bus.busy_o         = shifting || pend_v;
  assign bus.ready_o        = !pend_v;
  assign bus.drop_o         = drop_q;

endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream: MSB- and LSB-first instances, same stimulus,
// checked against a word-queue reference model.
module tb_serializer_stream;

  localparam int W       = 16;
  localparam int MW      = $clog2(W);
  localparam int MIN_LEN = 3;

  typedef struct {
    logic [W-1:0] d;
    int           len;
  } word_t;

  logic          clk     = 1'b0;
  logic          arstn   = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [MW-1:0] in_mod  = '0;
  logic          in_val  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  word_t wq[$];
  int    k        = 0;
  bit    exp_drop = 1'b0;

  int          m_cnt, l_cnt, b_cnt, run, max_run;
  logic [31:0] m_acc, l_acc;

  always #5 clk = ~clk;

  serializer_stream_if #(.DATA_BUS_WIDTH(W)) bm ();
  serializer_stream_if #(.DATA_BUS_WIDTH(W)) bl ();

  assign bm.data_i     = in_data;
  assign bm.data_mod_i = in_mod;
  assign bm.data_val_i = in_val;
  assign bl.data_i     = in_data;
  assign bl.data_mod_i = in_mod;
  assign bl.data_val_i = in_val;

  serializer_stream #(
    .DATA_BUS_WIDTH(W),
    .MIN_LEN(MIN_LEN),
    .LSB_FIRST(1'b0)
  ) u_msb (
    .clk_i(clk),
    .arstn_i(arstn),
    .bus(bm.slave)
  );

  serializer_stream #(
    .DATA_BUS_WIDTH(W),
    .MIN_LEN(MIN_LEN),
    .LSB_FIRST(1'b1)
  ) u_lsb (
    .clk_i(clk),
    .arstn_i(arstn),
    .bus(bl.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int len_of(input logic [MW-1:0] m);
    return (m == '0) ? W : int'(m);
  endfunction

  // Reference: queue holds current word (head) and pending word.
  task automatic model_edge();
    bit rdy;
    int ln;
    rdy = (wq.size() < 2);
    ln  = len_of(in_mod);
    exp_drop = in_val && rdy && (ln < MIN_LEN);
    if (wq.size() > 0) begin
      k++;
      if (k == wq[0].len) begin
        wq.delete(0);
        k = 0;
      end
    end
    if (in_val && rdy && (ln >= MIN_LEN))
      wq.push_back('{in_data, ln});
  endtask

  task automatic compare_all();
    bit   ev;
    logic eb_m;
    logic eb_l;
    ev   = (wq.size() > 0);
    eb_m = 1'b0;
    eb_l = 1'b0;
    if (ev) begin
      eb_m = wq[0].d[W-1-k];
      eb_l = wq[0].d[k];
    end
    check("m_val",   bm.ser_data_val_o, ev);
    check("m_bit",   bm.ser_data_o, eb_m);
    check("m_busy",  bm.busy_o, ev);
    check("m_ready", bm.ready_o, wq.size() < 2);
    check("m_drop",  bm.drop_o, exp_drop);
    check("l_val",   bl.ser_data_val_o, ev);
    check("l_bit",   bl.ser_data_o, eb_l);
    check("l_busy",  bl.busy_o, ev);
    check("l_ready", bl.ready_o, wq.size() < 2);
    check("l_drop",  bl.drop_o, exp_drop);
    if (bm.ser_data_val_o) begin
      m_cnt++;
      m_acc = {m_acc[30:0], bm.ser_data_o};
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (bl.ser_data_val_o) begin
      l_cnt++;
      l_acc = {l_acc[30:0], bl.ser_data_o};
    end
    if (bm.busy_o) b_cnt++;
  endtask

  task automatic clr();
    m_cnt = 0; l_cnt = 0; b_cnt = 0;
    run = 0; max_run = 0;
    m_acc = '0; l_acc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic offer(input logic [W-1:0] d,
                       input logic [MW-1:0] m);
    bit took;
    in_data = d;
    in_mod  = m;
    in_val  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      took = (wq.size() < 2);
      tick();
      if (took) return;
    end
    check("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_val = 1'b0;
    repeat (n) tick();
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_val"},   bm.ser_data_val_o, 1'b0);
    check({tag, "_bit"},   bm.ser_data_o, 1'b0);
    check({tag, "_busy"},  bm.busy_o, 1'b0);
    check({tag, "_drop"},  bm.drop_o, 1'b0);
    check({tag, "_ready"}, bm.ready_o, 1'b1);
    check({tag, "_lval"},  bl.ser_data_val_o, 1'b0);
    check({tag, "_lbusy"}, bl.busy_o, 1'b0);
  endtask

  // Called at a falling edge; resets between edges.
  task automatic async_reset();
    in_val = 1'b0;
    #2 arstn = 1'b0;
    #1 reset_check("arst");
    wq.delete();
    k = 0;
    exp_drop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare_all();
    #2 arstn = 1'b1;
  endtask

  initial begin
    bit took;
    clr();
    #3 reset_check("rst");
    @(negedge clk);
    #2 arstn = 1'b1;

    clr();
    offer(16'hA5C3, 4'd0);
    idle(18);
    check("a5c3_cnt",  m_cnt, 16);
    check("a5c3_bits", m_acc[15:0], 16'hA5C3);
    check("a5c3_busy", b_cnt, 16);

    clr();
    offer(16'h00B6, 4'd5);
    idle(8);
    check("b6_lcnt",  l_cnt, 5);
    check("b6_lbits", l_acc[4:0], 5'b01101);
    check("b6_mbits", m_acc[4:0], 5'b00000);

    clr();
    offer(16'hFFFF, 4'd2);
    check("rej_drop", bm.drop_o, 1'b1);
    idle(4);
    check("rej_cnt",  m_cnt, 0);
    check("rej_busy", b_cnt, 0);

    clr();
    offer(16'hFFFF, 4'd0);
    offer(16'h0000, 4'd4);
    check("b2b_ready", bm.ready_o, 1'b0);
    offer(16'hA000, 4'd4);
    idle(26);
    check("b2b_cnt",  m_cnt, 24);
    check("b2b_bits", m_acc[23:0], 24'hFFFF0A);
    check("b2b_run",  max_run, 24);

    offer(16'h1234, 4'd0);
    idle(5);
    async_reset();
    clr();
    offer(16'h9C3E, 4'd0);
    check("post_rst_val", bm.ser_data_val_o, 1'b1);
    idle(18);
    check("post_rst_bits", m_acc[15:0], 16'h9C3E);
    check("post_rst_cnt",  m_cnt, 16);

    took = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        async_reset();
        took = 1'b1;
      end
      if (!(in_val && !took)) begin
        in_val  = ($urandom_range(0, 99) < 65);
        in_data = W'($urandom);
        in_mod  = MW'($urandom);
      end
      took = (wq.size() < 2);
      tick();
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
- Parametrised successor to the single-word serializer.
- Accepts parallel words with a length field over a valid/ready handshake and emits them one bit per clock.
- Has a one-word pending buffer, so back-to-back words stream with zero idle cycles between them.
- Supports selectable bit order.
- Sits between a parallel producer (packetiser/DMA) and a serial line driver.

Parameters:
- DATA_BUS_WIDTH, 16, parallel word width; must be a power of two, >= 4.
- DATA_MOD_WIDTH, $clog2(DATA_BUS_WIDTH), width of the length field; derived, not overridden.
- MIN_LEN, 3, shortest accepted transfer length in bits, 1..DATA_BUS_WIDTH.
- LSB_FIRST, 0, 0 = MSB first, 1 = LSB first.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- arstn_i  in  1  asynchronous active-low reset
- data_i  in  DATA_BUS_WIDTH  parallel word
- data_mod_i  in  DATA_MOD_WIDTH  transfer length; 0 = DATA_BUS_WIDTH bits
- data_val_i  in  1  word valid
- ready_o  out  1  block can accept a word this cycle
- ser_data_o  out  1  serial bit
- ser_data_val_o  out  1  ser_data_o valid
- busy_o  out  1  a word is shifting or pending
- drop_o  out  1  one-cycle pulse: offered word rejected as too short

Behaviour:
- Reset: arstn_i low asynchronously forces the following; first operation is possible on the first clock edge after release.
  - State IDLE, pending buffer empty, counters 0.
  - ser_data_o = 0, ser_data_val_o = 0, busy_o = 0, drop_o = 0, ready_o = 1.
- Length: len = (data_mod_i == 0) ? DATA_BUS_WIDTH : data_mod_i.
- Bit selection:
  - MSB-first sends data[W-1] down to data[W-len].
  - LSB-first sends data[0] up to data[len-1].
- Accept condition: data_val_i && ready_o && len >= MIN_LEN.
- Reject condition: data_val_i && ready_o && len < MIN_LEN.
  - Word discarded; drop_o = 1 in the next cycle.
  - No serial output, no state change.
- data_val_i with ready_o low: ignored, nothing latched. Upstream must hold the word.
- ready_o = !pending_valid, which is registered.
- State SHIFT_S / IDLE_S:
  - IDLE_S: on accept, load the shift register and bit counter. Go to SHIFT_S. The first bit appears the next cycle (latency 1).
  - SHIFT_S: ser_data_val_o = 1 and one bit per cycle. The counter tracks remaining bits.
  - On the last-bit cycle:
    - Pending valid: load pending into the shift register, clear pending, stay in SHIFT_S. The next word's first bit follows the next cycle, with no gap.
    - Pending empty and an accept this cycle: load directly and stay in SHIFT_S, no gap.
    - Otherwise: go to IDLE_S.
  - Not on the last-bit cycle: an accept writes the pending buffer (data + len).
- Outputs in IDLE_S: ser_data_o = 0, ser_data_val_o = 0.
- busy_o = (state == SHIFT_S) || pending_valid.
- ser_data_o and ser_data_val_o are registered (driven from the shift register), glitch-free.
- Counter width: $clog2(DATA_BUS_WIDTH)+1 bits, so a full-width length is representable without wrap.
- Reset mid-transfer: the in-flight word and pending word are lost. Outputs drop to reset values immediately (asynchronously).
- Unknown state encoding: recover to IDLE_S on the next clock.

Test Plan:
- Single word, MSB-first:
  - Stimulus: data_i = 16'hA5C3, data_mod_i = 0, one-cycle valid in IDLE.
  - Response: 16 bits 1010_0101_1100_0011 on cycles 1..16, ser_data_val_o high exactly 16 cycles, busy_o high 16 cycles.
- Short length, LSB_FIRST = 1:
  - Stimulus: data_i = 16'h00B6, data_mod_i = 5.
  - Response: bits 0,1,1,0,1 then ser_data_val_o low.
- Rejection:
  - Stimulus: data_mod_i = 2 with data_val_i, MIN_LEN = 3.
  - Response: drop_o pulse the next cycle, no ser_data_val_o, busy_o stays 0.
- Back-to-back streaming:
  - Stimulus: word 16'hFFFF (len 16) accepted, then 16'h0000 len 4 offered while shifting.
  - Response: ready_o falls after the second accept. Bits: 16 ones immediately followed by 4 zeros, ser_data_val_o continuous for 20 cycles. ready_o rises when pending is consumed.
- Backpressure:
  - Stimulus: third word offered while pending is full.
  - Response: not latched. The word is accepted on the first cycle ready_o = 1, and the serial stream has no gap.
- Asynchronous reset:
  - Stimulus: assert arstn_i low mid-word, between clock edges.
  - Response: ser_data_val_o, busy_o, and ser_data_o go to 0 immediately. After release, a new word serializes correctly with latency 1.
